// File: rtl/register_file.sv
// register_file: multi-register storage with one write port and two
// combinational read ports. Register 0 always reads as zero. A same-cycle
// write to a read address is forwarded to that read port. A saturating
// counter tracks committed writes since reset.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [15:0]           wr_count
);

    localparam int unsigned REG_COUNT = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] array_a;
    logic [DATA_WIDTH-1:0] array_b;
    logic                  bypass_a;
    logic                  bypass_b;

    // A write commits only outside reset and never to register 0. The same
    // qualifier gates forwarding, so forwarding is suppressed during reset.
    always_comb begin
        wr_commit = wr_en && !rst && (wr_addr != '0);
    end

    // Register array: reset clears everything, otherwise load on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Saturating committed-write counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_commit && (wr_count != '1)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Read port A: array lookup with register 0 forced to zero, then forward.
    always_comb begin
        array_a   = '0;
        bypass_a  = 1'b0;
        if (rd_addr_a != '0) begin
            array_a = regs[rd_addr_a];
        end
        bypass_a  = wr_commit && (wr_addr == rd_addr_a);
        rd_data_a = bypass_a ? wr_data : array_a;
    end

    // Read port B: same structure as port A, forwarding decided independently.
    always_comb begin
        array_b   = '0;
        bypass_b  = 1'b0;
        if (rd_addr_b != '0) begin
            array_b = regs[rd_addr_b];
        end
        bypass_b  = wr_commit && (wr_addr == rd_addr_b);
        rd_data_b = bypass_b ? wr_data : array_b;
    end

endmodule
